// File: rtl/wb_pkg.sv
// Shared sizing helpers and entry layout for the posted-store write buffer.
package wb_pkg;

  localparam int WB_DEPTH_DEF  = 4;
  localparam int WB_ADDR_W_DEF = 32;
  localparam int WB_DATA_W_DEF = 32;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CNT_W = cnt_w(WB_DEPTH_DEF);

  typedef struct packed {
    logic [WB_ADDR_W_DEF-3:0] word_addr;
    logic [WB_DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Store-to-load forwarding match: youngest valid entry wins, scanning back from tail-1.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH_DEF,
  parameter int AW     = WB_ADDR_W_DEF - 2,
  parameter int DATA_W = WB_DATA_W_DEF,
  parameter int PTR_W  = ptr_w(DEPTH),
  parameter int CNT_W  = cnt_w(DEPTH)
) (
  input  logic [DEPTH-1:0][AW-1:0]     word_addr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
  input  logic [PTR_W-1:0]             tail_i,
  input  logic [CNT_W-1:0]             count_i,
  input  logic [AW-1:0]                addr_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o
);

  logic [PTR_W-1:0] idx;

  // Only the count_i most recent slots are live; older slots may hold stale data.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      idx = tail_i - PTR_W'(k);
      if (!hit_o && (CNT_W'(k) <= count_i) && (word_addr_i[idx] == addr_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-store FIFO between the M stage and data memory with load forwarding.
// Optional in-place merge of back-to-back stores to the youngest entry: WB_COALESCE_EN.
module mem_write_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH_DEF,
  parameter int ADDR_W = WB_ADDR_W_DEF,
  parameter int DATA_W = WB_DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cpu_we,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       stall,
  output logic [ADDR_W-1:0]          mem_raddr,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       mem_wreq,
  output logic [ADDR_W-1:0]          mem_waddr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_wack,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int AW    = ADDR_W - 2;

  logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [DEPTH-1:0][AW-1:0]     waddr_q;
  logic [DEPTH-1:0][DATA_W-1:0] wdata_q;

  logic [AW-1:0]    cpu_word;
  logic [PTR_W-1:0] youngest;
  logic             full, push, pop, merge;
  logic             fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic             unused_byte_sel;

  assign cpu_word        = cpu_addr[ADDR_W-1:2];
  assign unused_byte_sel = ^cpu_addr[1:0];
  assign youngest        = tail_q - PTR_W'(1);
  assign full            = (count_q == CNT_W'(DEPTH));

`ifdef WB_COALESCE_EN
  // Head is excluded so an in-flight write never changes under the handshake.
  assign merge = cpu_we && (count_q >= CNT_W'(2)) &&
                 (waddr_q[youngest] == cpu_word) && (youngest != head_q);
`else
  assign merge = 1'b0;
`endif

  assign stall = cpu_we & full & ~merge;
  assign push  = cpu_we & ~full & ~merge;
  assign pop   = (count_q != '0) & mem_wack;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: validity comes entirely from head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      waddr_q[tail_q] <= cpu_word;
      wdata_q[tail_q] <= cpu_wdata;
    end else if (merge) begin
      wdata_q[youngest] <= cpu_wdata;
    end
  end

  wb_fwd_match #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W),
    .CNT_W  (CNT_W)
  ) u_fwd (
    .word_addr_i (waddr_q),
    .data_i      (wdata_q),
    .tail_i      (tail_q),
    .count_i     (count_q),
    .addr_i      (cpu_word),
    .hit_o       (fwd_hit),
    .data_o      (fwd_data)
  );

  assign cpu_rdata = fwd_hit ? fwd_data : mem_rdata;
  assign mem_raddr = cpu_addr;
  assign mem_wreq  = (count_q != '0);
  assign mem_waddr = {waddr_q[head_q], 2'b00};
  assign mem_wdata = wdata_q[head_q];
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer (DEPTH=4, 32-bit address/data).
module tb_mem_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wreq;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wack;
  logic        empty;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_write_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_wreq  (mem_wreq),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_wack  (mem_wack),
    .empty     (empty),
    .count     (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    tick();
    cpu_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0; mem_wack = 1'b0;
    #3;
    chk("rst_wreq", {31'd0, mem_wreq}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    #9 reset = 1'b0;
    tick();

    // single store held un-acked for three cycles
    store(32'h40, 32'h11);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t1_wreq", {31'd0, mem_wreq}, 32'd1);
      chk("t1_waddr", mem_waddr, 32'h40);
      chk("t1_wdata", mem_wdata, 32'h11);
      tick();
    end
    mem_wack = 1'b1;
    tick();
    mem_wack = 1'b0;
    #1;
    chk("t1_empty", {31'd0, empty}, 32'd1);
    chk("t1_wreq_off", {31'd0, mem_wreq}, 32'd0);

    // forwarding picks the youngest of two same-address stores
    store(32'h10, 32'hA);
    store(32'h10, 32'hB);
    cpu_addr = 32'h10; mem_rdata = 32'hDEAD;
    #1;
    chk("t2_fwd", cpu_rdata, 32'hB);
    chk("t2_raddr", mem_raddr, 32'h10);
    cpu_addr = 32'h14;
    #1;
    chk("t2_miss", cpu_rdata, 32'hDEAD);
    cpu_we = 1'b1; cpu_addr = 32'h18; cpu_wdata = 32'h77;
    #1;
    chk("t2_noself", cpu_rdata, 32'hDEAD);
    cpu_we = 1'b0; cpu_addr = 32'h10; mem_wack = 1'b1;
    #1;
    chk("t2_fwd_acking", cpu_rdata, 32'hB);
    tick();
    #1;
    chk("t2_head2_addr", mem_waddr, 32'h10);
    chk("t2_head2_data", mem_wdata, 32'hB);
    chk("t2_cnt1", {29'd0, count}, 32'd1);
    tick();
    mem_wack = 1'b0;
    #1;
    chk("t2_empty", {31'd0, empty}, 32'd1);

    // fill to DEPTH, fifth store stalls even with a same-cycle ack
    store(32'h0, 32'h1);
    store(32'h4, 32'h2);
    store(32'h8, 32'h3);
    store(32'hC, 32'h4);
    cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h5;
    #1;
    chk("t3_stall", {31'd0, stall}, 32'd1);
    chk("t3_count", {29'd0, count}, 32'd4);
    chk("t3_drain0", mem_waddr, 32'h0);
    mem_wack = 1'b1;
    #1;
    chk("t3_stall_ack", {31'd0, stall}, 32'd1);
    tick();
    mem_wack = 1'b0;
    #1;
    chk("t3_count3", {29'd0, count}, 32'd3);
    chk("t3_unstall", {31'd0, stall}, 32'd0);
    tick();
    cpu_we = 1'b0;
    #1;
    chk("t3_count4", {29'd0, count}, 32'd4);
    mem_wack = 1'b1;
    chk("t3_drain1", mem_waddr, 32'h4);  tick();
    chk("t3_drain2", mem_waddr, 32'h8);  tick();
    chk("t3_drain3", mem_waddr, 32'hC);  tick();
    chk("t3_drain4", mem_waddr, 32'h20);
    chk("t3_drain4d", mem_wdata, 32'h5); tick();
    chk("t3_empty", {31'd0, empty}, 32'd1);
    tick();
    chk("t3_idle_ack", {29'd0, count}, 32'd0);
    mem_wack = 1'b0;

    // push and pop together at count==1
    store(32'h28, 32'h1);
    cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h55; mem_wack = 1'b1;
    tick();
    cpu_we = 1'b0; mem_wack = 1'b0;
    #1;
    chk("t4_count", {29'd0, count}, 32'd1);
    chk("t4_waddr", mem_waddr, 32'h30);
    chk("t4_wdata", mem_wdata, 32'h55);
    mem_wack = 1'b1;
    tick();
    mem_wack = 1'b0;

    // asynchronous reset mid-drain
    store(32'h100, 32'h1);
    store(32'h104, 32'h2);
    store(32'h108, 32'h3);
    chk("t5_wreq_pre", {31'd0, mem_wreq}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_wreq", {31'd0, mem_wreq}, 32'd0);
    chk("t5_count", {29'd0, count}, 32'd0);
    chk("t5_empty", {31'd0, empty}, 32'd1);
    reset = 1'b0;
    cpu_addr = 32'h100; mem_rdata = 32'hBEEF;
    #1;
    chk("t5_load", cpu_rdata, 32'hBEEF);
    tick();

    // store to the youngest entry's address
    store(32'h0, 32'h1);
    store(32'h8, 32'h2);
    store(32'h8, 32'h99);
`ifdef WB_COALESCE_EN
    chk("t6_merge_cnt", {29'd0, count}, 32'd2);
    store(32'h0, 32'h7);
    chk("t6_alloc_cnt", {29'd0, count}, 32'd3);
    mem_wack = 1'b1;
    chk("t6_d0a", mem_waddr, 32'h0); chk("t6_d0d", mem_wdata, 32'h1);  tick();
    chk("t6_d1a", mem_waddr, 32'h8); chk("t6_d1d", mem_wdata, 32'h99); tick();
    chk("t6_d2a", mem_waddr, 32'h0); chk("t6_d2d", mem_wdata, 32'h7);  tick();
`else
    chk("t6_alloc_cnt", {29'd0, count}, 32'd3);
    mem_wack = 1'b1;
    chk("t6_d0a", mem_waddr, 32'h0); chk("t6_d0d", mem_wdata, 32'h1);  tick();
    chk("t6_d1a", mem_waddr, 32'h8); chk("t6_d1d", mem_wdata, 32'h2);  tick();
    chk("t6_d2a", mem_waddr, 32'h8); chk("t6_d2d", mem_wdata, 32'h99); tick();
`endif
    mem_wack = 1'b0;
    chk("t6_empty", {31'd0, empty}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_write_buffer.md
Name: mem_write_buffer

Overview:
- Posted-store buffer between the pipeline's memory stage (memwrite/aluout/writedata/readdata) and data memory.
- Stores are queued in order and drained to memory through a req/ack write port, so a slow memory write never stalls the M stage unless the buffer is full.
- Loads see buffered data through store-to-load forwarding. Reads are otherwise passed through combinationally to the memory read port.

Parameters:
- DEPTH, 4, number of buffered store entries (power of two, >=2)
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- cpu_we  input  1  store request from M stage (memwritem)
- cpu_addr  input  ADDR_W  byte address from M stage (aluoutm)
- cpu_wdata  input  DATA_W  store data (writedatam)
- cpu_rdata  output  DATA_W  load data to M stage (readdatam)
- stall  output  1  store could not be accepted this cycle; pipeline must hold the M stage
- mem_raddr  output  ADDR_W  memory read address
- mem_rdata  input  DATA_W  memory combinational read data
- mem_wreq  output  1  write request to memory
- mem_waddr  output  ADDR_W  write address of head entry
- mem_wdata  output  DATA_W  write data of head entry
- mem_wack  input  1  memory accepted write this cycle
- empty  output  1  no entries buffered
- count  output  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset values (asynchronous, active-high):
  - head, tail and count are 0; all entries invalid.
  - mem_wreq=0, empty=1, stall=0.
  - Reset mid-drain discards all entries, including an un-acked head.
- Storage:
  - Circular array of {word address cpu_addr[ADDR_W-1:2], data}.
  - head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is tracked separately so full and empty are unambiguous.
- Enqueue:
  - Occurs at the posedge when cpu_we=1 and count<DEPTH.
  - The entry is written at tail, tail increments, zero-cycle acceptance.
- Stall:
  - stall = cpu_we & (count==DEPTH), purely from registered state; it never depends on mem_wack.
  - A full buffer with a same-cycle ack still stalls; the store enqueues on the next cycle.
- Drain handshake:
  - mem_wreq = (count!=0); mem_waddr = {head word addr, 2'b00}; mem_wdata = head data.
  - While mem_wreq=1 and mem_wack=0, mem_waddr and mem_wdata must stay stable.
  - On mem_wreq & mem_wack at the posedge: head increments, count decrements.
  - mem_wack while mem_wreq=0 is ignored.
- Simultaneous push and pop: count is unchanged and both pointers advance. This covers count==1, where the new entry becomes head next cycle.
- Ordering: strictly FIFO; stores reach memory in program order.
- Read path:
  - mem_raddr = cpu_addr, combinational.
  - cpu_rdata = data of the youngest valid entry whose word address equals cpu_addr[ADDR_W-1:2], otherwise mem_rdata.
  - Forwarding ignores cpu_we, so a same-cycle store does not forward to itself.
  - An entry being acked this cycle still forwards this cycle.
- Latency:
  - Store to memory request: 1 cycle after enqueue, if the buffer was empty.
  - Load forwarding: 0 cycles, combinational.
- empty = (count==0).

Optional Feature:
- Macro: WB_COALESCE_EN.
- When defined, and all four conditions hold:
  - cpu_we=1;
  - count>=2;
  - the youngest entry (tail-1) has the same word address as cpu_addr;
  - tail-1 != head;
- then the store overwrites that entry's data in place. tail and count are unchanged and stall=0 even when full.
- The head entry is never modified, which preserves handshake stability.
- When not defined, every store allocates a new entry.

Decomposition:
- Package wb_pkg:
  - WB_DEPTH_DEF, PTR_W function ($clog2), CNT_W.
  - typedef wb_entry_t {word_addr[ADDR_W-3:0], data[DATA_W-1:0]}.
- Sub-module wb_fwd_match: priority match over DEPTH entries, youngest-first from tail-1 backward, qualified by count. Outputs hit and data.

Test Plan:
- Store 0x11 to addr 0x40, mem_wack held 0 for 3 cycles, then 1:
  - Next cycle mem_wreq=1, mem_waddr=0x40, mem_wdata=0x11, both stable 3 cycles.
  - Entry pops on ack; empty=1 after.
- Stores 0xA to 0x10 then 0xB to 0x10 with no ack, then load 0x10 (mem_rdata=0xDEAD):
  - cpu_rdata=0xB.
  - Load 0x14 returns 0xDEAD.
- mem_wack=0, 5 stores to 0x0,0x4,0x8,0xC,0x20 (DEPTH=4):
  - The 5th store sees stall=1, count=4.
  - After one ack, the 5th store enqueues.
  - The drain order observed at mem_waddr is 0x0,0x4,0x8,0xC,0x20.
- count==1, store 0x55 to 0x30 in the same cycle as mem_wack=1:
  - count stays 1.
  - Next cycle mem_waddr=0x30, mem_wdata=0x55.
- Reset asserted with 3 entries and mem_wreq=1:
  - mem_wreq=0, count=0 and empty=1 immediately (asynchronous).
  - A subsequent load returns mem_rdata.
- WB_COALESCE_EN: entries 0x0 (head), 0x8; store 0x99 to 0x8:
  - count stays 2; drain writes 0x8 with 0x99 once.
  - Store to 0x0 allocates a new entry (count=3).
